// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, read-only instruction cache answering PC-unit fetches.
// A hit returns the word one cycle after the fetch is accepted. A miss raises stall
// and refills the whole line from memory, one word per mem_ready beat.
module inst_cache #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned WORD_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  ce,
    input  logic                  flush,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  inst_valid,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned LINES     = 1 << INDEX_BITS;
    localparam int unsigned WORDS     = 1 << WORD_BITS;
    localparam int unsigned OFFS_BITS = WORD_BITS + 2;
    localparam int unsigned TAG_BITS  = ADDR_WIDTH - INDEX_BITS - OFFS_BITS;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [WORD_BITS-1:0]    beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]   fill_addr_q, fill_addr_d;
    logic                    flush_seen_q, flush_seen_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   inst_q, inst_d;
    logic                    inst_valid_q, inst_valid_d;
    logic                    stall_raw;
    logic                    data_we;
    logic                    tag_we;

    logic [DATA_WIDTH-1:0]   data_q [LINES][WORDS];
    logic [TAG_BITS-1:0]     tag_q  [LINES];

    logic [WORD_BITS-1:0]    pc_word;
    logic [INDEX_BITS-1:0]   pc_index;
    logic [TAG_BITS-1:0]     pc_tag;
    logic [INDEX_BITS-1:0]   fill_index;
    logic [TAG_BITS-1:0]     fill_tag;
    logic                    hit;
    logic                    last_beat;
    logic                    unused_pc_bits;

    // Address decode for the lookup (pc) and for the line being refilled
    assign pc_word        = pc[OFFS_BITS-1:2];
    assign pc_index       = pc[OFFS_BITS +: INDEX_BITS];
    assign pc_tag         = pc[ADDR_WIDTH-1 -: TAG_BITS];
    assign fill_index     = fill_addr_q[OFFS_BITS +: INDEX_BITS];
    assign fill_tag       = fill_addr_q[ADDR_WIDTH-1 -: TAG_BITS];
    assign unused_pc_bits = ^pc[1:0];

    assign hit       = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign last_beat = (beat_q == WORD_BITS'(WORDS - 1));

    // Stall is a same-cycle answer to the PC unit; forced low while in reset
    assign stall      = stall_raw & rst;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign mem_req    = (state_q == REFILL);
    assign mem_addr   = fill_addr_q | ADDR_WIDTH'({beat_q, 2'b00});

    // State and control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            fill_addr_q  <= '0;
            flush_seen_q <= 1'b0;
            valid_q      <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            fill_addr_q  <= fill_addr_d;
            flush_seen_q <= flush_seen_d;
            valid_q      <= valid_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Line storage: data and tags carry no reset, valid bits gate their use
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[fill_index][beat_q] <= mem_rdata;
        end
        if (tag_we) begin
            tag_q[fill_index] <= fill_tag;
        end
    end

    // Next-state: lookup in IDLE, line refill in REFILL, flush clears all valid bits
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        fill_addr_d  = fill_addr_q;
        flush_seen_d = flush_seen_q;
        valid_d      = valid_q;
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        stall_raw    = 1'b0;
        data_we      = 1'b0;
        tag_we       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ce) begin
                    if (hit) begin
                        inst_d       = data_q[pc_index][pc_word];
                        inst_valid_d = 1'b1;
                    end else begin
                        stall_raw    = 1'b1;
                        fill_addr_d  = {pc[ADDR_WIDTH-1:OFFS_BITS], OFFS_BITS'(0)};
                        beat_d       = '0;
                        flush_seen_d = 1'b0;
                        state_d      = REFILL;
                    end
                end
                if (flush) begin
                    valid_d = '0;
                end
            end
            REFILL: begin
                stall_raw = 1'b1;
                if (flush) begin
                    valid_d      = '0;
                    flush_seen_d = 1'b1;
                end
                if (mem_ready) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + WORD_BITS'(1);
                    if (last_beat) begin
                        tag_we  = 1'b1;
                        state_d = IDLE;
                        if (!flush && !flush_seen_q) begin
                            valid_d[fill_index] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: table-driven fetch sequences against a behavioural memory,
// with a scoreboard that checks every returned instruction and its cycle.
module tb_inst_cache;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        ce;
    logic        flush;
    logic        stall;
    logic [31:0] inst;
    logic        inst_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    inst_cache dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .ce         (ce),
        .flush      (flush),
        .stall      (stall),
        .inst       (inst),
        .inst_valid (inst_valid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          beats;
        int          wait_cyc;
        int          flush_beat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } sb_t;

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;
    int  ready_div = 1;
    int  ready_cnt = 0;
    sb_t sb[$];
    vec_t vecs[$];

    function automatic logic [31:0] mword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic vec_t mkv(input logic [31:0] a, input int b, input int w, input int fb);
        vec_t v;
        v.addr       = a;
        v.data       = mword(a & 32'hFFFF_FFFC);
        v.beats      = b;
        v.wait_cyc   = w;
        v.flush_beat = fb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: random junk when not requested, ready every ready_div-th requested cycle
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                mem_ready = ((ready_cnt % ready_div) == (ready_div - 1));
                ready_cnt++;
                mem_rdata = mem_ready ? mword(mem_addr) : $urandom;
            end else begin
                mem_ready = ($urandom_range(0, 1) == 1);
                mem_rdata = $urandom;
            end
        end
    end

    // Scoreboard: each accepted fetch must show up exactly one edge later
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (inst_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_inst: got %h with no fetch pending (t=%0t)", inst, $time);
                end else begin
                    e = sb.pop_front();
                    check("inst_cycle", 32'(cyc), 32'(e.cyc));
                    check("inst_data", inst, e.data);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missing_inst: inst_valid 0, expected %h at cycle %0d", e.data, e.cyc);
            end
        end
    end

    // One fetch: hold pc until stall drops, track beats and addresses, optionally pulse flush
    task automatic run_vec(input vec_t v);
        logic [31:0] base;
        int          beats;
        int          waited;
        bit          flushed;
        bit          done;
        base    = v.addr & 32'hFFFF_FFF0;
        beats   = 0;
        waited  = 0;
        flushed = 1'b0;
        done    = 1'b0;
        pc      = v.addr;
        ce      = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            #1;
            if (!stall) begin
                check("mem_req_on_hit", 32'(mem_req), 32'd0);
                flush = (v.flush_beat == -2);
                sb.push_back('{data: v.data, cyc: cyc + 1});
                done = 1'b1;
            end else begin
                waited++;
                flush = 1'b0;
                if (mem_req) begin
                    check("mem_addr", mem_addr, base + 32'(4 * (beats % 4)));
                    if (v.flush_beat == beats && !flushed) begin
                        flush   = 1'b1;
                        flushed = 1'b1;
                    end
                    if (mem_ready) beats++;
                end
            end
            @(negedge clk);
        end
        flush = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL fetch_timeout: pc %h still stalled, expected release", v.addr);
        end
        check("beats", 32'(beats), 32'(v.beats));
        if (v.wait_cyc >= 0) check("stall_cycles", 32'(waited), 32'(v.wait_cyc));
    endtask

    initial begin
        int beats;
        rst   = 1'b0;
        ce    = 1'b1;
        pc    = '0;
        flush = 1'b0;

        // Fast-memory sequence: cold miss, streaming, conflicts, byte offset, wrap, flushes
        vecs.push_back(mkv(32'h0000_0000, 4, 5, -1));
        vecs.push_back(mkv(32'h0000_0004, 0, 0, -1));
        vecs.push_back(mkv(32'h0000_0008, 0, 0, -1));
        vecs.push_back(mkv(32'h0000_000C, 0, 0, -1));
        vecs.push_back(mkv(32'h0000_0400, 4, 5, -1));
        vecs.push_back(mkv(32'h0000_0000, 4, 5, -1));
        vecs.push_back(mkv(32'h0000_0006, 0, 0, -1));
        vecs.push_back(mkv(32'h0000_0404, 4, 5, -1));
        vecs.push_back(mkv(32'h0000_0010, 4, 5, -1));
        vecs.push_back(mkv(32'h0000_001C, 0, 0, -1));
        vecs.push_back(mkv(32'h1000_0010, 4, 5, -1));
        vecs.push_back(mkv(32'hFFFF_FFF0, 4, 5, -1));
        vecs.push_back(mkv(32'hFFFF_FFFC, 0, 0, -1));
        vecs.push_back(mkv(32'h0000_0020, 8, 10, 2));
        vecs.push_back(mkv(32'h0000_0024, 0, 0, -1));
        vecs.push_back(mkv(32'h0000_0028, 0, 0, -2));
        vecs.push_back(mkv(32'h0000_002C, 4, 5, -1));

        // Reset values, with ce high so stall must be masked
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_stall_held", 32'(stall), 32'd0);
        rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Slow memory: one beat every third requested cycle
        ready_div = 3;
        ready_cnt = 0;
        run_vec(mkv(32'h0000_0040, 4, -1, -1));
        run_vec(mkv(32'h0000_0044, 0, 0, -1));
        ready_div = 1;

        // Async reset in the middle of a refill
        pc    = 32'h0000_0300;
        ce    = 1'b1;
        beats = 0;
        for (int c = 0; c < 50 && !(beats == 1 && mem_req); c++) begin
            @(negedge clk);
            #1;
            if (mem_req && mem_ready) beats++;
        end
        check("pre_reset_mem_req", 32'(mem_req), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("async_mem_req", 32'(mem_req), 32'd0);
        check("async_stall", 32'(stall), 32'd0);
        check("async_inst_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_vec(mkv(32'h0000_0300, 4, 5, -1));
        run_vec(mkv(32'h0000_0308, 0, 0, -1));

        // Idle: inst_valid drops, inst holds, everything drained
        ce = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("idle_inst_valid", 32'(inst_valid), 32'd0);
        check("idle_inst_hold", inst, mword(32'h0000_0308));
        check("idle_stall", 32'(stall), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Instruction-fetch responder that sits at the other end of the fetch interface from the PC unit.
- Accepts pc/ce and returns the instruction word one cycle later.
- Raises stall toward the PC unit on a miss, so the PC holds its address.
- Direct-mapped, read-only; refills whole lines from main memory over a word-per-beat ready handshake; flush input invalidates all lines.

Parameters:
- ADDR_WIDTH, 32, instruction address width (matches PC output).
- DATA_WIDTH, 32, instruction word width.
- INDEX_BITS, 6, log2 of line count (64 lines).
- WORD_BITS, 2, log2 of words per line (4 words = 16 bytes).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- pc  in  ADDR_WIDTH  fetch address from PC unit; bits [1:0] ignored.
- ce  in  1  fetch enable from PC unit.
- flush  in  1  invalidate all lines (fence/self-modify).
- stall  out  1  to PC unit; 1 = hold pc.
- inst  out  DATA_WIDTH  fetched instruction.
- inst_valid  out  1  inst holds the word for the pc accepted last cycle.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_WIDTH  word-aligned memory read address.
- mem_ready  in  1  beat accepted; mem_rdata valid this cycle.
- mem_rdata  in  DATA_WIDTH  memory read data.

Behaviour:
- Address split: [1:0] byte (ignored), [WORD_BITS+1:2] word, next INDEX_BITS index, remaining upper bits tag.
- Storage: data array, tag array, valid bit per line. Tag/data read combinationally from pc.
- hit = valid[index] && tag match.
- Reset (rst=0, async): stall=0, inst=0, inst_valid=0, mem_req=0, mem_addr=0, all valid bits 0, state=IDLE, beat=0.
- FSM states: IDLE, REFILL.
- IDLE:
  - stall = ce && !hit (combinational).
  - On a clock edge with ce=1 and hit: inst <= data[index][word], inst_valid <= 1. Latency is 1 cycle; back-to-back hits sustain 1 word/cycle.
  - ce=0: inst_valid <= 0, inst holds.
  - ce=1 and miss: inst_valid <= 0; latch the line base (pc with word and byte bits zeroed) into fill_addr; go to REFILL with beat=0.
- REFILL:
  - stall=1 and inst_valid=0 throughout.
  - mem_req=1, mem_addr = fill_addr + 4*beat.
  - Hold mem_req and mem_addr stable until mem_ready.
  - Each cycle with mem_ready: write mem_rdata into data[fill_index][beat], beat++.
  - On the last beat (beat = 2^WORD_BITS-1 with mem_ready): write the tag, set valid unless a flush occurred during this refill, return to IDLE with mem_req=0 on the next cycle.
  - pc changes during REFILL are ignored; the PC unit must hold pc while stall=1.
- After REFILL, the held pc is re-looked-up in IDLE. It hits, so stall drops and inst appears one cycle later. Miss-to-inst latency is 2^WORD_BITS memory beats + 2 cycles minimum.
- flush:
  - In IDLE: all valid bits cleared at the edge. A lookup in the same cycle uses the pre-flush state (hit allowed); the next cycle misses.
  - In REFILL: valid bits cleared; refill runs to completion, but its line is left invalid. The re-lookup then misses again and refetches.
- Memory data outside REFILL or with mem_req=0 is ignored.
- Reset mid-REFILL: mem_req drops immediately (async); partial line discarded.
- mem_addr wraps modulo 2^ADDR_WIDTH (no carry beyond the tag).

Test Plan:
- Cold miss: reset, rst=1, ce=1, pc=0x0. Expect stall=1; mem_addr 0x0,0x4,0x8,0xC with mem_ready each cycle. Then stall=0, and on the next cycle inst=mem[0x0], inst_valid=1.
- Streaming hits: after the cold miss, pc=0x4,0x8,0xC on consecutive cycles. Expect inst=mem[4],mem[8],mem[C] each one cycle later; stall=0, mem_req=0.
- Conflict eviction: fetch 0x0000, then 0x0400 (same index 0, different tag). Expect refill at 0x400..0x40C. Refetching 0x0000 then misses again.
- Slow memory: mem_ready only every 3rd cycle. Expect mem_addr held stable between beats; exactly 4 writes; inst correct.
- Flush mid-refill: pulse flush at beat 2 of a refill of 0x20. Expect refill to complete, an immediate second refill of 0x20, then inst=mem[0x20].
- Async reset during refill: rst=0 at beat 1. Expect mem_req=0 and stall=0 without waiting for a clock edge; the next fetch of the same address misses.
